mos6502s_indirect_ptr_fetch: RTL and testbench

Sequencer that consumes the pointer addresses from the indirect address calculator and reads the two pointer bytes from memory. It assembles the effective address for `(ind)` (mode 9), `(zp,X)` (mode 10) and `(zp),Y` (mode 11). It sits between the indirect address calculator and the operand fetch/execute stage of the mos6502s core, and owns the memory read port while busy.

---
 rtl/mos6502s_indirect_ptr_fetch_if.sv | 23 ++
 rtl/mos6502s_indirect_ptr_fetch.sv | 75 +++++++
 tb/tb_mos6502s_indirect_ptr_fetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mos6502s_indirect_ptr_fetch_if.sv
// mos6502s_indirect_ptr_fetch_if: request, completion and memory read bus of the indirect pointer fetcher
interface mos6502s_indirect_ptr_fetch_if;
  logic        start;
  logic [3:0]  mode;
  logic [15:0] ptr_addr_lo;
  logic [15:0] ptr_addr_hi;
  logic [7:0]  y_reg;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic [15:0] eff_addr;
  logic        page_cross;
  modport master (
    output start, mode, ptr_addr_lo, ptr_addr_hi, y_reg, mem_rdata,
    input  mem_addr, mem_rd, busy, done, eff_addr, page_cross
  );
  modport slave (
    input  start, mode, ptr_addr_lo, ptr_addr_hi, y_reg, mem_rdata,
    output mem_addr, mem_rd, busy, done, eff_addr, page_cross
  );
endinterface

// File: rtl/mos6502s_indirect_ptr_fetch.sv
// mos6502s_indirect_ptr_fetch: reads the two pointer bytes for (ind), (zp,X), (zp),Y and forms the effective address
// Define MOS6502S_PAGE_CROSS_PENALTY_EN to add the NMOS dummy read on a (zp),Y page cross.
module mos6502s_indirect_ptr_fetch (
  input logic clk,
  input logic rst,
  mos6502s_indirect_ptr_fetch_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, FIN, FIX, DONE} state_t;
  state_t      state;
  logic [3:0]  mode_q;
  logic [15:0] lo_ptr;
  logic [15:0] hi_ptr;
  logic [7:0]  y_q;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic [8:0]  lo_sum;
  logic [15:0] y_sum;
  assign lo_sum = {1'b0, lo_byte} + {1'b0, y_q};
  assign y_sum  = {bus.mem_rdata, lo_byte} + {8'h00, y_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= '0;
      lo_ptr         <= '0;
      hi_ptr         <= '0;
      y_q            <= '0;
      lo_byte        <= '0;
      hi_byte        <= '0;
      bus.eff_addr   <= '0;
      bus.page_cross <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          lo_ptr <= bus.ptr_addr_lo;
          hi_ptr <= bus.ptr_addr_hi;
          y_q    <= bus.y_reg;
          if (bus.mode inside {4'd9, 4'd10, 4'd11}) state <= RD_LO;
          else begin
            state          <= DONE;
            bus.eff_addr   <= '0;
            bus.page_cross <= 1'b0;
          end
        end
        RD_LO: state <= RD_HI;
        RD_HI: begin
          lo_byte <= bus.mem_rdata;
          state   <= FIN;
        end
        FIN: begin
          hi_byte        <= bus.mem_rdata;
          bus.eff_addr   <= (mode_q == 4'd11) ? y_sum : {bus.mem_rdata, lo_byte};
          bus.page_cross <= (mode_q == 4'd11) && lo_sum[8];
`ifdef MOS6502S_PAGE_CROSS_PENALTY_EN
          state <= (mode_q == 4'd11 && lo_sum[8]) ? FIX : DONE;
`else
          state <= DONE;
`endif
        end
        FIX:  state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // The FIX dummy read uses the un-carried high byte, as the NMOS part does.
  always_comb begin
    bus.busy     = state != IDLE;
    bus.done     = state == DONE;
    bus.mem_rd   = state inside {RD_LO, RD_HI, FIX};
    bus.mem_addr = state == RD_LO ? lo_ptr :
                   state == RD_HI ? hi_ptr :
                   state == FIX   ? {hi_byte, lo_sum[7:0]} : 16'h0000;
  end
endmodule

// File: tb/tb_mos6502s_indirect_ptr_fetch.sv
// tb_mos6502s_indirect_ptr_fetch: directed scoreboard bench for the indirect pointer fetcher
module tb_mos6502s_indirect_ptr_fetch;
`ifdef MOS6502S_PAGE_CROSS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mos6502s_indirect_ptr_fetch_if bus ();
  mos6502s_indirect_ptr_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [0:65535];
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 8'h00;
  typedef struct packed {
    logic [15:0]      eff;
    logic             pc;
    logic [3:0]       lat;
    logic [1:0]       nrd;
    logic [2:0][15:0] rd;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] rd_a[$];
  int rd_c[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] m, input logic [15:0] lo, input logic [15:0] hi,
                     input logic [7:0] y, input logic [15:0] eff, input logic pc,
                     input int lat, input int nrd, input logic [15:0] r0,
                     input logic [15:0] r1, input logic [15:0] r2, input bit glitch);
    exp_t e;
    exp_t g;
    int k;
    int extra;
    bit seen;
    e.eff = eff;
    e.pc  = pc;
    e.lat = 4'(lat);
    e.nrd = 2'(nrd);
    e.rd  = {r2, r1, r0};
    exp_q.push_back(e);
    rd_a.delete();
    rd_c.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.ptr_addr_lo = lo;
    bus.ptr_addr_hi = hi;
    bus.y_reg = y;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("busy_after_start", bus.busy, 1);
        bus.start = glitch;
        bus.mode = 4'd0;
        bus.ptr_addr_lo = 16'hDEAD;
        bus.ptr_addr_hi = 16'hBEEF;
        bus.y_reg = 8'hAA;
      end
      if (k == 2) bus.start = 1'b0;
      if (bus.mem_rd) begin
        rd_a.push_back(bus.mem_addr);
        rd_c.push_back(k);
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    g = exp_q.pop_front();
    check("done_seen", seen, 1);
    check("latency", k, g.lat);
    check("eff_addr", bus.eff_addr, g.eff);
    check("page_cross", bus.page_cross, g.pc);
    check("read_count", rd_a.size(), g.nrd);
    for (int i = 0; i < rd_a.size() && i < 3; i++) begin
      check("read_addr", rd_a[i], g.rd[i]);
      check("read_cycle", rd_c[i], (i < 2) ? i + 1 : 4);
    end
    @(negedge clk);
    check("idle_after_done", {bus.busy, bus.done, bus.mem_rd}, 0);
    check("eff_addr_held", bus.eff_addr, g.eff);
    if (glitch) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      check("start_not_queued", extra, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 4'd0;
    bus.ptr_addr_lo = '0;
    bus.ptr_addr_hi = '0;
    bus.y_reg = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    mem[16'h1234] = 8'h78; mem[16'h1235] = 8'h56;
    mem[16'h12FF] = 8'h34; mem[16'h1200] = 8'h12;
    mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h80;
    mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h20;
    mem[16'h0080] = 8'hFF; mem[16'h0081] = 8'hFF;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.mem_rd, bus.page_cross}, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_eff_addr", bus.eff_addr, 0);
    rst = 1'b0;
    req(4'd9,  16'h1234, 16'h1235, 8'h00, 16'h5678, 1'b0, 4, 2, 16'h1234, 16'h1235, 16'h0000, 1'b0);
    req(4'd9,  16'h12FF, 16'h1200, 8'h00, 16'h1234, 1'b0, 4, 2, 16'h12FF, 16'h1200, 16'h0000, 1'b0);
    req(4'd10, 16'h00FF, 16'h0000, 8'h00, 16'h8000, 1'b0, 4, 2, 16'h00FF, 16'h0000, 16'h0000, 1'b1);
    req(4'd11, 16'h0040, 16'h0041, 8'h20, 16'h2110, 1'b1, PEN ? 5 : 4, PEN ? 3 : 2,
        16'h0040, 16'h0041, 16'h2010, 1'b0);
    req(4'd11, 16'h0040, 16'h0041, 8'h0F, 16'h20FF, 1'b0, 4, 2, 16'h0040, 16'h0041, 16'h0000, 1'b0);
    req(4'd0,  16'h1234, 16'h1235, 8'h55, 16'h0000, 1'b0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    req(4'd11, 16'h0080, 16'h0081, 8'h01, 16'h0000, 1'b1, PEN ? 5 : 4, PEN ? 3 : 2,
        16'h0080, 16'h0081, 16'hFF00, 1'b0);
    req(4'd9,  16'h1234, 16'h1235, 8'h00, 16'h5678, 1'b0, 4, 2, 16'h1234, 16'h1235, 16'h0000, 1'b0);
    // Abort in RD_HI: reset is asynchronous, so outputs must clear before the next edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 4'd9;
    bus.ptr_addr_lo = 16'h12FF;
    bus.ptr_addr_hi = 16'h1200;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rd_hi_before_reset", bus.mem_addr, 16'h1200);
    rst = 1'b1;
    #1;
    check("reset_mid_flags", {bus.busy, bus.done, bus.mem_rd, bus.page_cross}, 0);
    check("reset_mid_mem_addr", bus.mem_addr, 0);
    check("reset_mid_eff_addr", bus.eff_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    req(4'd10, 16'h00FF, 16'h0000, 8'h00, 16'h8000, 1'b0, 4, 2, 16'h00FF, 16'h0000, 16'h0000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
